// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int ZERO_REG   = 0;

    // Net change of the pending-register count: +1 on a fresh set, -1 on a clear.
    function automatic logic signed [1:0] cnt_delta(input logic inc, input logic dec);
        return $signed({1'b0, inc}) - $signed({1'b0, dec});
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a live count of set bits.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic                  rsv_en,
    input  logic [ADDR_W-1:0]     rsv_addr,
    output logic [2**ADDR_W-1:0]  busy_o,
    output logic [ADDR_W:0]       busy_cnt_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0]   busy_q, busy_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic               rsv_v, wr_v, inc, dec;
    logic signed [1:0]  delta;

    always_comb begin
        rsv_v  = rsv_en && (rsv_addr != ADDR_W'(ZERO_REG));
        wr_v   = we && (waddr != ADDR_W'(ZERO_REG));
        busy_d = busy_q;
        // Reserve is applied after the clear so a new producer wins on a tie.
        if (wr_v)
            busy_d[waddr] = 1'b0;
        if (rsv_v)
            busy_d[rsv_addr] = 1'b1;
        busy_d[ZERO_REG] = 1'b0;
        inc   = rsv_v && !busy_q[rsv_addr];
        dec   = wr_v && busy_q[waddr] && !(rsv_v && (rsv_addr == waddr));
        delta = cnt_delta(inc, dec);
        cnt_d = cnt_q + {{(ADDR_W-1){delta[1]}}, delta};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass and pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    output logic [ADDR_W:0]            busy_cnt,
    input  logic [ADDR_W-1:0]          dbg_addr,
    output logic [DATA_W-1:0]          dbg_data
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy;

    regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .waddr      (waddr),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt)
    );

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++)
                mem_q[k] <= '0;
        end else if (we && (waddr != ADDR_W'(ZERO_REG))) begin
            mem_q[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] r;
        logic              wr_hit, rsv_hit;

        assign r       = raddr[i*ADDR_W +: ADDR_W];
        assign wr_hit  = we && (waddr == r);
        assign rsv_hit = rsv_en && (rsv_addr == r);

        assign rdata[i*DATA_W +: DATA_W] = (r == ADDR_W'(ZERO_REG)) ? '0 :
                                           wr_hit ? wdata : mem_q[r];
        // A write landing this cycle is forwarded, so it is not a stall unless re-reserved.
        assign rbusy[i] = busy[r] && !(wr_hit && !rsv_hit);
    end

    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default instance plus a 16-bit/8-entry/3-port instance.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default instance (32/5/2)
    logic        a_we, a_rsv_en;
    logic [4:0]  a_waddr, a_rsv_addr, a_dbg_addr;
    logic [31:0] a_wdata, a_dbg_data;
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;
    logic [5:0]  a_cnt;

    regfile_sb u_a (
        .clk(clk), .rst_n(rst_n), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
        .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .raddr(a_raddr), .rdata(a_rdata),
        .rbusy(a_rbusy), .busy_cnt(a_cnt), .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data)
    );

    // Small instance (16/3/3)
    logic        b_we, b_rsv_en;
    logic [2:0]  b_waddr, b_rsv_addr, b_dbg_addr;
    logic [15:0] b_wdata, b_dbg_data;
    logic [8:0]  b_raddr;
    logic [47:0] b_rdata;
    logic [2:0]  b_rbusy;
    logic [3:0]  b_cnt;

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) u_b (
        .clk(clk), .rst_n(rst_n), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .raddr(b_raddr), .rdata(b_rdata),
        .rbusy(b_rbusy), .busy_cnt(b_cnt), .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
    );

    localparam int K_A_RD0 = 0, K_A_RD1 = 1, K_A_RBUSY = 2, K_A_CNT = 3, K_A_DBG = 4;
    localparam int K_B_RD0 = 5, K_B_RD1 = 6, K_B_RD2 = 7, K_B_RBUSY = 8, K_B_CNT = 9, K_B_DBG = 10;

    // Scoreboard: expectations queued by the driver, drained by the monitor at negedge.
    logic [31:0] exp_q[$];
    int          kind_q[$];
    string       name_q[$];
    int          errors = 0;
    int          checks = 0;

    task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        kind_q.push_back(kind);
        name_q.push_back(name);
    endtask

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_A_RD0:   return a_rdata[31:0];
            K_A_RD1:   return a_rdata[63:32];
            K_A_RBUSY: return {30'd0, a_rbusy};
            K_A_CNT:   return {26'd0, a_cnt};
            K_A_DBG:   return a_dbg_data;
            K_B_RD0:   return {16'd0, b_rdata[15:0]};
            K_B_RD1:   return {16'd0, b_rdata[31:16]};
            K_B_RD2:   return {16'd0, b_rdata[47:32]};
            K_B_RBUSY: return {29'd0, b_rbusy};
            K_B_CNT:   return {28'd0, b_cnt};
            K_B_DBG:   return {16'd0, b_dbg_data};
            default:   return 32'hxxxx_xxxx;
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [31:0] e, g;
            int          k;
            string       n;
            e = exp_q.pop_front();
            k = kind_q.pop_front();
            n = name_q.pop_front();
            g = actual(k);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, g, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_we = 1'b0; a_rsv_en = 1'b0;
        b_we = 1'b0; b_rsv_en = 1'b0;
    endtask

    initial begin
        a_waddr = '0; a_wdata = '0; a_rsv_addr = '0; a_raddr = '0; a_dbg_addr = '0;
        b_waddr = '0; b_wdata = '0; b_rsv_addr = '0; b_raddr = '0; b_dbg_addr = '0;
        idle();

        // Reset state
        a_raddr = {5'd2, 5'd1};
        expect_val(K_A_RD0, 32'h0, "reset_rd0");
        expect_val(K_A_RBUSY, 32'h0, "reset_rbusy");
        expect_val(K_A_CNT, 32'h0, "reset_cnt");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Write r5 and reserve r6, then reset mid-operation
        a_we = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEADBEEF; a_raddr = {5'd0, 5'd5};
        expect_val(K_A_RD0, 32'hDEADBEEF, "wr5_bypass");
        step();
        idle(); a_rsv_en = 1'b1; a_rsv_addr = 5'd6; a_dbg_addr = 5'd5;
        expect_val(K_A_DBG, 32'hDEADBEEF, "wr5_dbg");
        expect_val(K_A_RD0, 32'hDEADBEEF, "wr5_rd0");
        step();
        idle();
        expect_val(K_A_CNT, 32'd1, "rsv6_cnt");
        step();
        rst_n = 1'b0;
        expect_val(K_A_RD0, 32'h0, "rst_rd5");
        expect_val(K_A_DBG, 32'h0, "rst_dbg5");
        expect_val(K_A_CNT, 32'h0, "rst_cnt");
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();

        // Bypass on r7, persistence after the edge
        a_we = 1'b1; a_waddr = 5'd7; a_wdata = 32'h12345678; a_raddr = {5'd5, 5'd7};
        expect_val(K_A_RD0, 32'h12345678, "byp_same");
        expect_val(K_A_RD1, 32'h0, "byp_r5_cleared");
        step();
        idle();
        expect_val(K_A_RD0, 32'h12345678, "byp_after");
        step();

        // Zero register: writes and reservations ignored
        a_we = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFFFFFF; a_raddr = {5'd0, 5'd0};
        expect_val(K_A_RD0, 32'h0, "r0_wr_rd");
        step();
        idle(); a_rsv_en = 1'b1; a_rsv_addr = 5'd0; a_dbg_addr = 5'd0;
        expect_val(K_A_DBG, 32'h0, "r0_dbg");
        step();
        idle();
        expect_val(K_A_CNT, 32'h0, "r0_cnt");
        expect_val(K_A_RBUSY, 32'h0, "r0_rbusy");
        expect_val(K_A_RD0, 32'h0, "r0_rd");
        step();

        // Scoreboard lifecycle on r3
        a_rsv_en = 1'b1; a_rsv_addr = 5'd3; a_raddr = {5'd5, 5'd3};
        expect_val(K_A_RBUSY, 32'h0, "rsv3_not_yet");
        step();
        idle();
        expect_val(K_A_RBUSY, 32'h1, "rsv3_busy");
        expect_val(K_A_CNT, 32'd1, "rsv3_cnt");
        step();
        a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'hA5;
        expect_val(K_A_RBUSY, 32'h0, "wr3_fwd_rbusy");
        expect_val(K_A_RD0, 32'hA5, "wr3_fwd_rd");
        expect_val(K_A_CNT, 32'd1, "wr3_cnt_pre");
        step();
        idle();
        expect_val(K_A_CNT, 32'd0, "wr3_cnt_post");
        expect_val(K_A_RBUSY, 32'h0, "wr3_rbusy_post");
        step();

        // Simultaneous reserve and write on r4
        a_we = 1'b1; a_waddr = 5'd4; a_wdata = 32'h11;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd4; a_raddr = {5'd5, 5'd4};
        expect_val(K_A_RD0, 32'h11, "rw4_bypass");
        expect_val(K_A_RBUSY, 32'h0, "rw4_rbusy");
        step();
        idle(); a_dbg_addr = 5'd4;
        expect_val(K_A_DBG, 32'h11, "rw4_dbg");
        expect_val(K_A_RBUSY, 32'h1, "rw4_busy");
        expect_val(K_A_CNT, 32'd1, "rw4_cnt");
        step();

        // Reserve r9 while writing busy r4: net count unchanged
        a_we = 1'b1; a_waddr = 5'd4; a_wdata = 32'h22;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd9; a_raddr = {5'd9, 5'd4};
        expect_val(K_A_RBUSY, 32'h0, "swap_rbusy_pre");
        step();
        idle();
        expect_val(K_A_CNT, 32'd1, "swap_cnt");
        expect_val(K_A_RBUSY, 32'h2, "swap_rbusy");
        expect_val(K_A_DBG, 32'h22, "swap_dbg4");
        step();

        // Re-reserve and write busy r9 together: stays busy, data forwarded
        a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'h99;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd9;
        expect_val(K_A_RBUSY, 32'h2, "rerw9_rbusy");
        expect_val(K_A_RD1, 32'h99, "rerw9_rd");
        step();
        idle();
        expect_val(K_A_CNT, 32'd1, "rerw9_cnt");
        step();

        // Small instance: fill every non-zero register, reserving each as it is written
        for (int k = 1; k < 8; k++) begin
            b_we = 1'b1; b_waddr = 3'(k); b_wdata = 16'h1100 + 16'(k);
            b_rsv_en = 1'b1; b_rsv_addr = 3'(k);
            expect_val(K_B_CNT, 32'(k - 1), "p_fill_cnt");
            step();
        end
        idle();
        b_raddr = {3'd7, 3'd5, 3'd2};
        expect_val(K_B_CNT, 32'd7, "p_cnt_full");
        expect_val(K_B_RD0, 32'h1102, "p_rd0");
        expect_val(K_B_RD1, 32'h1105, "p_rd1");
        expect_val(K_B_RD2, 32'h1107, "p_rd2");
        expect_val(K_B_RBUSY, 32'h7, "p_rbusy");
        step();
        b_rsv_en = 1'b1; b_rsv_addr = 3'd3; b_raddr = {3'd0, 3'd6, 3'd3};
        b_dbg_addr = 3'd6;
        expect_val(K_B_DBG, 32'h1106, "p_dbg6");
        expect_val(K_B_RBUSY, 32'h3, "p_rbusy_r0");
        step();
        idle();
        expect_val(K_B_CNT, 32'd7, "p_cnt_sat");
        expect_val(K_B_RD2, 32'h0, "p_rd_r0");
        step();
        b_we = 1'b1; b_waddr = 3'd6; b_wdata = 16'hBEEF;
        expect_val(K_B_RD1, 32'hBEEF, "p_wr6_bypass");
        step();
        idle();
        expect_val(K_B_CNT, 32'd6, "p_wr6_cnt");
        expect_val(K_B_RBUSY, 32'h1, "p_wr6_rbusy");
        step();
        step();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
